branch_predictor_btb: RTL and testbench



---
 rtl/branch_predictor_btb.sv | 110 +++++++++++
 tb/tb_branch_predictor_btb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with 2-bit counters, static or bimodal prediction.
// Optional statistics counters enabled by macro BP_STATS_EN. Revision 1.0
`default_nettype none

module branch_predictor_btb #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int MODE    = 1,
  parameter int STAT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [31:0]       i_if_pc,
  output logic              o_pred_hit,
  output logic              o_pred_taken,
  output logic [31:0]       o_pred_target,
  input  logic              i_ex_upd_vld,
  input  logic [31:0]       i_ex_pc,
  input  logic              i_ex_taken,
  input  logic [31:0]       i_ex_target,
  input  logic              i_ex_mispred,
  input  logic              i_bp_clr,
  output logic [STAT_W-1:0] o_stat_branches,
  output logic [STAT_W-1:0] o_stat_mispred
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr      [ENTRIES];
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [31:0]        tgt_mem  [ENTRIES];

  logic [IDX_W-1:0]   if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic [IDX_W-1:0]   ex_idx;
  logic [TAG_W-1:0]   ex_tag;
  logic               ex_hit;
  logic               lookup_taken;

  assign if_idx = i_if_pc[IDX_W+1:2];
  assign if_tag = i_if_pc[31:IDX_W+2];
  assign ex_idx = i_ex_pc[IDX_W+1:2];
  assign ex_tag = i_ex_pc[31:IDX_W+2];
  assign ex_hit = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);

  // Lookup reads the array state as of the last edge; no update bypass.
  assign o_pred_hit    = valid[if_idx] && (tag_mem[if_idx] == if_tag);
  assign lookup_taken  = (MODE == 0) ? 1'b1 : ctr[if_idx][1];
  assign o_pred_taken  = o_pred_hit && lookup_taken;
  assign o_pred_target = o_pred_taken ? tgt_mem[if_idx] : (i_if_pc + 32'd4);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i]     <= 2'b01;
        tag_mem[i] <= '0;
        tgt_mem[i] <= '0;
      end
    end else if (i_bp_clr) begin
      valid <= '0;
    end else if (i_ex_upd_vld) begin
      if (ex_hit) begin
        if (i_ex_taken) begin
          if (ctr[ex_idx] != 2'b11) ctr[ex_idx] <= ctr[ex_idx] + 2'b01;
          tgt_mem[ex_idx] <= i_ex_target;
        end else begin
          if (ctr[ex_idx] != 2'b00) ctr[ex_idx] <= ctr[ex_idx] - 2'b01;
        end
      end else if (i_ex_taken) begin
        valid[ex_idx]   <= 1'b1;
        tag_mem[ex_idx] <= ex_tag;
        tgt_mem[ex_idx] <= i_ex_target;
        ctr[ex_idx]     <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [STAT_W-1:0] stat_br;
  logic [STAT_W-1:0] stat_mp;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stat_br <= '0;
      stat_mp <= '0;
    end else if (i_bp_clr) begin
      stat_br <= '0;
      stat_mp <= '0;
    end else if (i_ex_upd_vld) begin
      if (stat_br != '1) stat_br <= stat_br + 1'b1;
      if (i_ex_mispred && (stat_mp != '1)) stat_mp <= stat_mp + 1'b1;
    end
  end

  assign o_stat_branches = stat_br;
  assign o_stat_mispred  = stat_mp;
`else
  assign o_stat_branches = '0;
  assign o_stat_mispred  = '0;
`endif

  // Byte-offset bits never participate in index or tag.
  logic unused_ok;
  assign unused_ok = ^{i_if_pc[1:0], i_ex_pc[1:0], i_ex_mispred};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed plan steps then random traffic vs a reference model.
`default_nettype none

module tb_branch_predictor_btb;

  localparam int ENTRIES = 32;
  localparam int IDX_W   = $clog2(ENTRIES);
`ifdef BP_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        ex_upd_vld;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispred;
  logic        bp_clr;

  logic        hit1, taken1, hit0, taken0;
  logic [31:0] tgt1, tgt0, sb1, sm1, sb0, sm0;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model state: one record per BTB slot.
  bit        mv   [ENTRIES];
  bit [31:0] mtag [ENTRIES];
  bit [31:0] mtgt [ENTRIES];
  int        mctr [ENTRIES];
  int        br_cnt, mp_cnt;

  always #5 clk = ~clk;

  branch_predictor_btb #(.ENTRIES(ENTRIES), .MODE(1), .STAT_W(32)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_if_pc(if_pc),
    .o_pred_hit(hit1), .o_pred_taken(taken1), .o_pred_target(tgt1),
    .i_ex_upd_vld(ex_upd_vld), .i_ex_pc(ex_pc), .i_ex_taken(ex_taken),
    .i_ex_target(ex_target), .i_ex_mispred(ex_mispred), .i_bp_clr(bp_clr),
    .o_stat_branches(sb1), .o_stat_mispred(sm1)
  );

  branch_predictor_btb #(.ENTRIES(ENTRIES), .MODE(0), .STAT_W(32)) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_if_pc(if_pc),
    .o_pred_hit(hit0), .o_pred_taken(taken0), .o_pred_target(tgt0),
    .i_ex_upd_vld(ex_upd_vld), .i_ex_pc(ex_pc), .i_ex_taken(ex_taken),
    .i_ex_target(ex_target), .i_ex_mispred(ex_mispred), .i_bp_clr(bp_clr),
    .o_stat_branches(sb0), .o_stat_mispred(sm0)
  );

  function automatic int slot(input bit [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit [31:0] tag_of(input bit [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 1;
    end
    br_cnt = 0;
    mp_cnt = 0;
  endtask

  task automatic model_update(input bit upd, input bit [31:0] pc, input bit tk,
                              input bit [31:0] tg, input bit mp, input bit clr);
    int i;
    i = slot(pc);
    if (clr) begin
      for (int k = 0; k < ENTRIES; k++) mv[k] = 0;
      br_cnt = 0;
      mp_cnt = 0;
    end else if (upd) begin
      br_cnt++;
      if (mp) mp_cnt++;
      if (mv[i] && mtag[i] == tag_of(pc)) begin
        if (tk) begin
          mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
          mtgt[i] = tg;
        end else begin
          mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
        end
      end else if (tk) begin
        mv[i] = 1; mtag[i] = tag_of(pc); mtgt[i] = tg; mctr[i] = 2;
      end
    end
  endtask

  task automatic check_outputs(input bit [31:0] pc);
    int  i;
    bit  h, t1, t0;
    bit [31:0] e1, e0, esb, esm;
    i  = slot(pc);
    h  = mv[i] && (mtag[i] == tag_of(pc));
    t1 = h && (mctr[i] >= 2);
    t0 = h;
    e1 = t1 ? mtgt[i] : pc + 32'd4;
    e0 = t0 ? mtgt[i] : pc + 32'd4;
    esb = STATS_ON ? 32'(br_cnt) : 32'd0;
    esm = STATS_ON ? 32'(mp_cnt) : 32'd0;
    chk("hit_m1",    {31'd0, hit1},   {31'd0, h});
    chk("taken_m1",  {31'd0, taken1}, {31'd0, t1});
    chk("target_m1", tgt1, e1);
    chk("hit_m0",    {31'd0, hit0},   {31'd0, h});
    chk("taken_m0",  {31'd0, taken0}, {31'd0, t0});
    chk("target_m0", tgt0, e0);
    chk("stat_br",   sb1, esb);
    chk("stat_mp",   sm1, esm);
    chk("stat_br_m0", sb0, esb);
    chk("stat_mp_m0", sm0, esm);
  endtask

  // Drive one cycle: lookup is checked before the edge (pre-update view), model follows the edge.
  task automatic step(input bit upd, input bit [31:0] pc, input bit tk, input bit [31:0] tg,
                      input bit mp, input bit clr, input bit [31:0] look);
    @(negedge clk);
    ex_upd_vld = upd; ex_pc = pc; ex_taken = tk; ex_target = tg;
    ex_mispred = mp; bp_clr = clr; if_pc = look;
    #1;
    check_outputs(look);
    @(posedge clk);
    model_update(upd, pc, tk, tg, mp, clr);
  endtask

  task automatic mid_reset(input bit [31:0] look);
    @(negedge clk);
    ex_upd_vld = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h1234;
    ex_mispred = 1'b1; bp_clr = 1'b0; if_pc = look;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_outputs(look);
    @(negedge clk);
    ex_upd_vld = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic idle(input bit [31:0] look);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, look);
  endtask

  initial begin
    bit [31:0] pc, tg, look;
    bit upd, tk, mp, clr;
    rstn = 1'b0; if_pc = 32'h100; ex_upd_vld = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_mispred = 1'b0; bp_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    idle(32'h100);
    step(1'b1, 32'h100, 1'b1, 32'h080, 1'b0, 1'b0, 32'h100);
    idle(32'h100);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100);
    idle(32'h100);
    step(1'b1, 32'h180, 1'b1, 32'h300, 1'b0, 1'b0, 32'h180);
    idle(32'h100);
    idle(32'h180);
    step(1'b1, 32'h100, 1'b1, 32'h080, 1'b0, 1'b0, 32'h100);
    step(1'b1, 32'h200, 1'b1, 32'h444, 1'b0, 1'b1, 32'h100);
    idle(32'h100);
    idle(32'h200);

    mid_reset(32'h100);
    for (int k = 0; k < 10; k++)
      step(1'b1, 32'h100 + 32'(k * 4), k[0], 32'h800 + 32'(k * 16), (k % 3) == 0, 1'b0, 32'h100);
    idle(32'h104);
    mid_reset(32'h104);

    for (int n = 0; n < 400; n++) begin
      pc   = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      look = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) look = pc;
      if (n == 200) look = 32'hFFFF_FFFC;
      tg   = $urandom;
      upd  = ($urandom_range(0, 9) < 7);
      tk   = $urandom_range(0, 1) == 1;
      mp   = $urandom_range(0, 3) == 0;
      clr  = ($urandom_range(0, 39) == 0);
      step(upd, pc, tk, tg, mp, clr, look);
    end
    idle(32'h100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
